// File: rtl/mem_access.sv
// mem_access: RV32 memory stage; byte/half/word load/store over a req/gnt/rvalid port, registered MD_* bus.
module mem_access #(
    parameter int XLEN        = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   E_valid_i,
    input  logic [INSTR_WIDTH-1:0] E_instr_i,
    input  logic [XLEN-1:0]        E_valE_i,
    input  logic [XLEN-1:0]        E_valB_i,
    input  logic                   E_sel_reg_i,
    input  logic                   E_mem_rd_i,
    input  logic                   E_mem_wr_i,
    input  logic [2:0]             E_funct3_i,
    input  logic [4:0]             E_rd_i,
    input  logic                   E_wb_en_i,
    output logic                   M_stall_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [XLEN-1:0]        dmem_addr_o,
    output logic [XLEN-1:0]        dmem_wdata_o,
    output logic [3:0]             dmem_wstrb_o,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    input  logic [XLEN-1:0]        dmem_rdata_i,
    output logic                   MD_valid_o,
    output logic [INSTR_WIDTH-1:0] MD_instr_o,
    output logic                   MD_sel_reg_o,
    output logic [XLEN-1:0]        MD_valE_o,
    output logic [XLEN-1:0]        MD_valM_o,
    output logic [4:0]             MD_rd_o,
    output logic                   MD_wb_en_o,
    output logic                   MD_misalign_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
    state_t state, state_nxt;
    logic                   is_mem, misalign, accept, done;
    logic [7:0]             byte_v;
    logic [15:0]            half_v;
    logic [XLEN-1:0]        load_val;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [XLEN-1:0]        valE_q;
    logic [2:0]             funct3_q;
    logic [4:0]             rd_q;
    logic                   sel_q, wb_q;

    always_comb begin
        is_mem    = E_mem_rd_i | E_mem_wr_i;
        misalign  = E_funct3_i[1:0] == 2'b00 ? 1'b0 :
                    E_funct3_i[1:0] == 2'b01 ? E_valE_i[0] : |E_valE_i[1:0];
        accept    = state == IDLE && E_valid_i;
        done      = (state == REQ && dmem_gnt_i && dmem_we_o) || (state == WAIT_R && dmem_rvalid_i);
        M_stall_o = state != IDLE;
        dmem_req_o = state == REQ;
        byte_v    = 8'(dmem_rdata_i >> {valE_q[1:0], 3'b000});
        half_v    = valE_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_val  = funct3_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                    funct3_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
                    funct3_q == 3'b100 ? {24'b0, byte_v} :
                    funct3_q == 3'b101 ? {16'b0, half_v} : dmem_rdata_i;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept && is_mem && !misalign ? REQ : IDLE;
            REQ:     state_nxt = !dmem_gnt_i ? REQ : dmem_we_o ? IDLE : WAIT_R;
            WAIT_R:  state_nxt = dmem_rvalid_i ? IDLE : WAIT_R;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        state <= !rst_n_i ? IDLE : state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dmem_we_o     <= 1'b0;
            dmem_addr_o   <= '0;
            dmem_wdata_o  <= '0;
            dmem_wstrb_o  <= '0;
            instr_q       <= '0;
            valE_q        <= '0;
            funct3_q      <= '0;
            rd_q          <= '0;
            sel_q         <= 1'b0;
            wb_q          <= 1'b0;
            MD_valid_o    <= 1'b0;
            MD_instr_o    <= '0;
            MD_sel_reg_o  <= 1'b0;
            MD_valE_o     <= '0;
            MD_valM_o     <= '0;
            MD_rd_o       <= '0;
            MD_wb_en_o    <= 1'b0;
            MD_misalign_o <= 1'b0;
        end else begin
            MD_valid_o <= 1'b0;
            if (accept && is_mem && !misalign) begin
                instr_q      <= E_instr_i;
                valE_q       <= E_valE_i;
                funct3_q     <= E_funct3_i;
                rd_q         <= E_rd_i;
                sel_q        <= E_sel_reg_i;
                wb_q         <= E_wb_en_i;
                dmem_we_o    <= E_mem_wr_i;
                dmem_addr_o  <= {E_valE_i[XLEN-1:2], 2'b00};
                dmem_wdata_o <= E_funct3_i[1:0] == 2'b00 ? {4{E_valB_i[7:0]}} :
                                E_funct3_i[1:0] == 2'b01 ? {2{E_valB_i[15:0]}} : E_valB_i;
                dmem_wstrb_o <= E_funct3_i[1:0] == 2'b00 ? 4'b0001 << E_valE_i[1:0] :
                                E_funct3_i[1:0] == 2'b01 ? (E_valE_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            end else if (accept) begin
                // misaligned memory ops complete here as a flagged, non-writing pass-through
                MD_valid_o    <= 1'b1;
                MD_instr_o    <= E_instr_i;
                MD_sel_reg_o  <= E_sel_reg_i;
                MD_valE_o     <= E_valE_i;
                MD_valM_o     <= '0;
                MD_rd_o       <= E_rd_i;
                MD_wb_en_o    <= E_wb_en_i & ~(is_mem & misalign);
                MD_misalign_o <= is_mem & misalign;
            end else if (done) begin
                MD_valid_o    <= 1'b1;
                MD_instr_o    <= instr_q;
                MD_sel_reg_o  <= sel_q;
                MD_valE_o     <= valE_q;
                MD_valM_o     <= dmem_we_o ? '0 : load_val;
                MD_rd_o       <= rd_q;
                MD_wb_en_o    <= wb_q;
                MD_misalign_o <= 1'b0;
            end
        end
    end
endmodule
